// File: rtl/splitting_128bit.sv
// Serializes a 128-bit block into four 32-bit words over a valid/ready stream.
// Word order is selected by MSW_FIRST; a new block can be taken on the last word's cycle.
module splitting_128bit #(
    parameter int unsigned MSW_FIRST = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [127:0] data_in,
    input  logic         load,
    output logic         in_ready,
    input  logic         abort,
    output logic [31:0]  data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         last,
    output logic [2:0]   counter
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   buf_q, buf_d;
    logic [2:0]     counter_q, counter_d;

    logic           block_xfer;
    logic           word_xfer;
    logic           final_word;
    logic [127:0]   buf_shifted;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            counter_q <= counter_d;
        end
    end

    // The buffer is always zero in IDLE, so the emitted slice needs no gating.
    always_comb begin
        if (MSW_FIRST != 0) begin
            data_out    = buf_q[127:96];
            buf_shifted = {buf_q[95:0], 32'h0};
        end else begin
            data_out    = buf_q[31:0];
            buf_shifted = {32'h0, buf_q[127:32]};
        end
    end

    always_comb begin
        final_word = (state_q == SEND) && (counter_q == 3'd3);
        out_valid  = (state_q == SEND);
        last       = final_word;
        counter    = counter_q;
        // out_ready feeds in_ready combinationally so back-to-back blocks have no bubble.
        in_ready   = (state_q == IDLE) || (final_word && out_ready && !abort);
        word_xfer  = out_valid && out_ready;
        block_xfer = load && in_ready;
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        counter_d = counter_q;
        if (abort) begin
            state_d   = IDLE;
            buf_d     = '0;
            counter_d = 3'd0;
        end else if (block_xfer) begin
            state_d   = SEND;
            buf_d     = data_in;
            counter_d = 3'd0;
        end else if (word_xfer) begin
            if (final_word) begin
                state_d   = IDLE;
                buf_d     = '0;
                counter_d = 3'd4;
            end else begin
                buf_d     = buf_shifted;
                counter_d = counter_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_splitting_128bit.sv
// Randomized and directed bench for splitting_128bit; both word orders run side by side
// against a block/word-index model.
module tb_splitting_128bit;

    logic         CLK;
    logic         RST_N;
    logic [127:0] data_in;
    logic         load;
    logic         abort;
    logic         out_ready;

    logic         d1_in_ready, d1_out_valid, d1_last;
    logic [31:0]  d1_data_out;
    logic [2:0]   d1_counter;
    logic         d0_in_ready, d0_out_valid, d0_last;
    logic [31:0]  d0_data_out;
    logic [2:0]   d0_counter;

    int checks = 0;
    int errors = 0;

    splitting_128bit #(.MSW_FIRST(1)) dut_msw (
        .CLK(CLK), .RST_N(RST_N), .data_in(data_in), .load(load),
        .in_ready(d1_in_ready), .abort(abort), .data_out(d1_data_out),
        .out_valid(d1_out_valid), .out_ready(out_ready), .last(d1_last),
        .counter(d1_counter)
    );

    splitting_128bit #(.MSW_FIRST(0)) dut_lsw (
        .CLK(CLK), .RST_N(RST_N), .data_in(data_in), .load(load),
        .in_ready(d0_in_ready), .abort(abort), .data_out(d0_data_out),
        .out_valid(d0_out_valid), .out_ready(out_ready), .last(d0_last),
        .counter(d0_counter)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the held block, how many words have left it, and whether one is held.
    logic [127:0] m_blk;
    int           m_cnt;
    logic         m_active;

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int k, input bit msw);
        logic [127:0] sh;
        sh = msw ? (blk >> (96 - 32 * k)) : (blk >> (32 * k));
        return sh[31:0];
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_blk    <= '0;
        end else if (abort) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (load && (!m_active || (m_cnt == 3 && out_ready))) begin
            m_blk    <= data_in;
            m_cnt    <= 0;
            m_active <= 1'b1;
        end else if (m_active && out_ready) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 3) m_active <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            logic        e_rdy;
            logic [31:0] e_w1, e_w0;
            e_rdy = !m_active || (m_cnt == 3 && out_ready && !abort);
            e_w1  = m_active ? word_of(m_blk, m_cnt, 1'b1) : 32'h0;
            e_w0  = m_active ? word_of(m_blk, m_cnt, 1'b0) : 32'h0;
            chk("in_ready_msw",  {31'h0, d1_in_ready},  {31'h0, e_rdy});
            chk("out_valid_msw", {31'h0, d1_out_valid}, {31'h0, m_active});
            chk("data_out_msw",  d1_data_out, e_w1);
            chk("last_msw",      {31'h0, d1_last}, {31'h0, (m_active && m_cnt == 3)});
            chk("counter_msw",   {29'h0, d1_counter}, m_cnt[31:0]);
            chk("in_ready_lsw",  {31'h0, d0_in_ready},  {31'h0, e_rdy});
            chk("out_valid_lsw", {31'h0, d0_out_valid}, {31'h0, m_active});
            chk("data_out_lsw",  d0_data_out, e_w0);
            chk("last_lsw",      {31'h0, d0_last}, {31'h0, (m_active && m_cnt == 3)});
            chk("counter_lsw",   {29'h0, d0_counter}, m_cnt[31:0]);
        end
    end

    // Snapshot of outputs taken at the falling edge of each step.
    logic        s_v, s_last, s_rdy;
    logic [31:0] s_w1, s_w0;
    logic [2:0]  s_cnt;

    task automatic step(input logic ld, input logic [127:0] d, input logic ordy, input logic ab);
        load = ld; data_in = d; out_ready = ordy; abort = ab;
        @(negedge CLK);
        s_v = d1_out_valid; s_last = d1_last; s_rdy = d1_in_ready;
        s_w1 = d1_data_out; s_w0 = d0_data_out; s_cnt = d1_counter;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_C = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

    logic [31:0] exp_msw [4];
    logic [31:0] exp_lsw [4];
    logic [31:0] exp_c   [4];
    logic [31:0] got_q [$];

    initial begin
        exp_msw = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        exp_lsw = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        exp_c   = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};

        RST_N = 1'b0; load = 0; abort = 0; out_ready = 0; data_in = '0;
        #2;
        chk("reset_in_ready", {31'h0, d1_in_ready}, 32'h1);
        chk("reset_out_valid", {31'h0, d1_out_valid}, 32'h0);
        chk("reset_counter", {29'h0, d1_counter}, 32'h0);
        chk("reset_data_out", d1_data_out, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Basic drain, both orders.
        step(1'b1, BLK_A, 1'b1, 1'b0);
        chk("load_in_ready", {31'h0, s_rdy}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_msw_word", s_w1, exp_msw[k]);
            chk("drain_lsw_word", s_w0, exp_lsw[k]);
            chk("drain_counter", {29'h0, s_cnt}, k);
            chk("drain_last", {31'h0, s_last}, {31'h0, (k == 3)});
            chk("drain_valid", {31'h0, s_v}, 32'h1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("done_counter", {29'h0, s_cnt}, 32'h4);
        chk("done_valid", {31'h0, s_v}, 32'h0);

        // Stalled sink: words hold while out_ready is low.
        step(1'b1, BLK_A, 1'b0, 1'b0);
        begin
            logic        pv, pr;
            logic [31:0] pw;
            pv = 0; pr = 1; pw = 0;
            got_q.delete();
            for (int i = 0; i < 16; i++) begin
                logic ordy;
                ordy = (i % 3 == 0);
                step(1'b0, '0, ordy, 1'b0);
                if (pv && !pr && s_v) chk("stall_hold", s_w1, pw);
                if (s_v && ordy) got_q.push_back(s_w1);
                pv = s_v; pr = ordy; pw = s_w1;
            end
        end
        chk("stall_count", got_q.size(), 32'd4);
        for (int j = 0; j < 4 && j < got_q.size(); j++)
            chk("stall_word", got_q[j], exp_msw[j]);

        // Back-to-back blocks with load held high.
        step(1'b1, BLK_A, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(i <= 3, BLK_C, 1'b1, 1'b0);
            chk("b2b_valid", {31'h0, s_v}, 32'h1);
            chk("b2b_word", s_w1, (i < 4) ? exp_msw[i] : exp_c[i - 4]);
            if (i == 3) chk("b2b_in_ready", {31'h0, s_rdy}, 32'h1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("b2b_end_valid", {31'h0, s_v}, 32'h0);

        // Abort beats a simultaneous load.
        step(1'b1, BLK_A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, BLK_C, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("abort_valid", {31'h0, s_v}, 32'h0);
        chk("abort_counter", {29'h0, s_cnt}, 32'h0);
        chk("abort_in_ready", {31'h0, s_rdy}, 32'h1);
        step(1'b1, BLK_C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("post_abort_valid", {31'h0, s_v}, 32'h1);
        chk("post_abort_word", s_w1, exp_c[0]);

        // Asynchronous reset mid-block.
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, BLK_A, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("arst_valid", {31'h0, d1_out_valid}, 32'h0);
        chk("arst_counter", {29'h0, d1_counter}, 32'h0);
        chk("arst_data", d1_data_out, 32'h0);
        chk("arst_last", {31'h0, d1_last}, 32'h0);
        chk("arst_in_ready", {31'h0, d1_in_ready}, 32'h1);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("arst_no_words", {31'h0, s_v}, 32'h0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1,
                 {$urandom, $urandom, $urandom, $urandom},
                 ($urandom % 4) != 0,
                 ($urandom % 32) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
